// File: rtl/alu16_pkg.sv
// Shared word width, word type and opcode encoding for the ALU16 block.
package alu16_pkg;

    localparam int WIDTH = 16;

    typedef logic [WIDTH-1:0] word_t;

    typedef enum logic [3:0] {
        OP_TSA  = 4'h0,
        OP_INC  = 4'h1,
        OP_DEC  = 4'h2,
        OP_ADD  = 4'h3,
        OP_SUB  = 4'h4,
        OP_AND  = 4'h5,
        OP_OR   = 4'h6,
        OP_XOR  = 4'h7,
        OP_NOT  = 4'h8,
        OP_SHL  = 4'h9,
        OP_SHR  = 4'hA,
        OP_ASR  = 4'hB,
        OP_RLC  = 4'hC,
        OP_RRC  = 4'hD,
        OP_BREV = 4'hE,
        OP_RSV  = 4'hF
    } op_e;

endpackage

// File: rtl/alu16_if.sv
// Operand/opcode bus into the ALU and registered result/flags back out.
interface alu16_if;
    import alu16_pkg::*;

    word_t      abus;
    word_t      bbus;
    logic [3:0] fsel;
    logic       cin;
    word_t      fout;
    logic       z;
    logic       s;
    logic       c;
    logic       v;

    modport master (output abus, bbus, fsel, cin, input fout, z, s, c, v);
    modport slave  (input abus, bbus, fsel, cin, output fout, z, s, c, v);

endinterface

// File: rtl/alu16_addsub.sv
// Shared 16-bit adder/subtractor; carry reports borrow when subtracting.
module alu16_addsub
    import alu16_pkg::*;
(
    input  word_t a,
    input  word_t b,
    input  logic  sub,
    output word_t sum,
    output logic  carry,
    output logic  ovf
);

    word_t b_eff;
    logic  co;

    // a - b computed as a + ~b + 1; no carry-out then means a borrow occurred
    assign b_eff     = sub ? ~b : b;
    assign {co, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    assign carry     = co ^ sub;
    assign ovf       = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu16.sv
// 16-bit ALU: combinational result mux into one output register (1-cycle latency).
// Define ALU16_BREV_EN to enable the byte-swap opcode E; otherwise E acts as RSV.
module alu16
    import alu16_pkg::*;
(
    input  logic   clk,
    input  logic   reset_n,
    alu16_if.slave bus
);

    op_e   op;
    word_t a;
    word_t as_b;
    logic  as_sub;
    word_t as_sum;
    logic  as_carry;
    logic  as_ovf;
    word_t res;
    logic  c_nxt;
    logic  v_nxt;

    assign op = op_e'(bus.fsel);
    assign a  = bus.abus;

    // INC/DEC reuse the adder with a constant 1 as the second operand
    always_comb begin
        as_b   = bus.bbus;
        as_sub = 1'b0;
        case (op)
            OP_INC:  as_b = word_t'(1);
            OP_DEC:  begin as_b = word_t'(1); as_sub = 1'b1; end
            OP_SUB:  as_sub = 1'b1;
            default: ;
        endcase
    end

    alu16_addsub u_addsub (
        .a     (a),
        .b     (as_b),
        .sub   (as_sub),
        .sum   (as_sum),
        .carry (as_carry),
        .ovf   (as_ovf)
    );

    always_comb begin
        res   = '0;
        c_nxt = 1'b0;
        v_nxt = 1'b0;
        case (op)
            OP_TSA: res = a;
            OP_INC, OP_DEC, OP_ADD, OP_SUB: begin
                res   = as_sum;
                c_nxt = as_carry;
                v_nxt = as_ovf;
            end
            OP_AND: res = a & bus.bbus;
            OP_OR:  res = a | bus.bbus;
            OP_XOR: res = a ^ bus.bbus;
            OP_NOT: res = ~a;
            OP_SHL: begin
                res   = {a[WIDTH-2:0], 1'b0};
                c_nxt = a[WIDTH-1];
                v_nxt = a[WIDTH-1] ^ res[WIDTH-1];
            end
            OP_SHR: begin
                res   = {1'b0, a[WIDTH-1:1]};
                c_nxt = a[0];
                v_nxt = a[WIDTH-1] ^ res[WIDTH-1];
            end
            OP_ASR: begin
                res   = {a[WIDTH-1], a[WIDTH-1:1]};
                c_nxt = a[0];
            end
            OP_RLC: begin
                res   = {a[WIDTH-2:0], bus.cin};
                c_nxt = a[WIDTH-1];
                v_nxt = a[WIDTH-1] ^ res[WIDTH-1];
            end
            OP_RRC: begin
                res   = {bus.cin, a[WIDTH-1:1]};
                c_nxt = a[0];
                v_nxt = a[WIDTH-1] ^ res[WIDTH-1];
            end
`ifdef ALU16_BREV_EN
            OP_BREV: res = {a[7:0], a[15:8]};
`endif
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.fout <= '0;
            bus.z    <= 1'b0;
            bus.s    <= 1'b0;
            bus.c    <= 1'b0;
            bus.v    <= 1'b0;
        end else begin
            bus.fout <= res;
            bus.z    <= (res == '0);
            bus.s    <= res[WIDTH-1];
            bus.c    <= c_nxt;
            bus.v    <= v_nxt;
        end
    end

endmodule

// File: tb/tb_alu16.sv
// Self-checking bench for alu16: reset sequences, directed vector table, random model vectors.
module tb_alu16;
    import alu16_pkg::*;

    typedef struct packed {
        word_t f;
        logic  z;
        logic  s;
        logic  c;
        logic  v;
    } res_t;

    typedef struct {
        string name;
        op_e   op;
        word_t a;
        word_t b;
        logic  cin;
        res_t  exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    alu16_if bus ();

    alu16 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    res_t exp_q[$];
    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic res_t mk_res(word_t f, logic z, logic s, logic c, logic v);
        res_t r;
        r.f = f; r.z = z; r.s = s; r.c = c; r.v = v;
        return r;
    endfunction

    function automatic vec_t mk_vec(string name, op_e op, word_t a, word_t b, logic cin, res_t exp);
        vec_t t;
        t.name = name; t.op = op; t.a = a; t.b = b; t.cin = cin; t.exp = exp;
        return t;
    endfunction

    // Reference model using signed/unsigned integer arithmetic
    function automatic res_t model(op_e op, word_t a, word_t b, logic cin);
        res_t r;
        int ua, ub, sa, sb, t;
        ua = int'(a);
        ub = int'(b);
        sa = a[15] ? ua - 65536 : ua;
        sb = b[15] ? ub - 65536 : ub;
        r = '0;
        case (op)
            OP_TSA: r.f = a;
            OP_INC: begin r.f = word_t'(ua + 1); r.c = (ua + 1) > 65535; r.v = (sa + 1) > 32767; end
            OP_DEC: begin r.f = word_t'(ua - 1); r.c = (ua == 0); r.v = (sa - 1) < -32768; end
            OP_ADD: begin
                r.f = word_t'(ua + ub); r.c = (ua + ub) > 65535;
                t = sa + sb; r.v = (t > 32767) || (t < -32768);
            end
            OP_SUB: begin
                r.f = word_t'(ua - ub); r.c = ua < ub;
                t = sa - sb; r.v = (t > 32767) || (t < -32768);
            end
            OP_AND: r.f = a & b;
            OP_OR:  r.f = a | b;
            OP_XOR: r.f = a ^ b;
            OP_NOT: r.f = ~a;
            OP_SHL: begin r.f = word_t'(ua * 2); r.c = a[15]; r.v = a[15] ^ r.f[15]; end
            OP_SHR: begin r.f = word_t'(ua / 2); r.c = a[0]; r.v = a[15] ^ r.f[15]; end
            OP_ASR: begin r.f = word_t'(sa >>> 1); r.c = a[0]; end
            OP_RLC: begin r.f = word_t'(ua * 2 + int'(cin)); r.c = a[15]; r.v = a[15] ^ r.f[15]; end
            OP_RRC: begin r.f = word_t'(ua / 2 + (cin ? 32768 : 0)); r.c = a[0]; r.v = a[15] ^ r.f[15]; end
`ifdef ALU16_BREV_EN
            OP_BREV: r.f = {a[7:0], a[15:8]};
`endif
            default: r.f = '0;
        endcase
        r.z = (r.f == '0);
        r.s = r.f[15];
        return r;
    endfunction

    task automatic apply(input string name, input logic rst, input op_e op, input word_t a,
                         input word_t b, input logic cin, input res_t exp);
        res_t got, want;
        @(negedge clk);
        reset_n  = rst;
        bus.fsel = op;
        bus.abus = a;
        bus.bbus = b;
        bus.cin  = cin;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        got  = {bus.fout, bus.z, bus.s, bus.c, bus.v};
        want = exp_q.pop_front();
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got fout=%h zscv=%b%b%b%b, want fout=%h zscv=%b%b%b%b",
                     name, got.f, got.z, got.s, got.c, got.v,
                     want.f, want.z, want.s, want.c, want.v);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        bus.fsel = OP_ADD;
        bus.abus = 16'h0001;
        bus.bbus = 16'h0001;
        bus.cin  = 1'b0;

        // Reset sequences
        apply("reset_init",     1'b0, OP_ADD, 16'h0001, 16'h0001, 1'b0, mk_res(16'h0000, 0, 0, 0, 0));
        apply("reset_release",  1'b1, OP_ADD, 16'h0001, 16'h0001, 1'b0, mk_res(16'h0002, 0, 0, 0, 0));
        apply("pre_reset_add",  1'b1, OP_ADD, 16'h8000, 16'hFFFF, 1'b0, mk_res(16'h7FFF, 0, 0, 1, 1));
        apply("reset_priority", 1'b0, OP_SUB, 16'h8000, 16'h0001, 1'b0, mk_res(16'h0000, 0, 0, 0, 0));
        apply("reset_rerelease",1'b1, OP_ADD, 16'h0001, 16'h0001, 1'b0, mk_res(16'h0002, 0, 0, 0, 0));

        // Directed table
        vecs.push_back(mk_vec("add_ovf_neg",  OP_ADD, 16'h8000, 16'hFFFF, 1'b0, mk_res(16'h7FFF, 0, 0, 1, 1)));
        vecs.push_back(mk_vec("add_ovf_pos",  OP_ADD, 16'h7FFF, 16'h0001, 1'b0, mk_res(16'h8000, 0, 1, 0, 1)));
        vecs.push_back(mk_vec("add_carry",    OP_ADD, 16'hFFFB, 16'h0006, 1'b0, mk_res(16'h0001, 0, 0, 1, 0)));
        vecs.push_back(mk_vec("add_cin_ign",  OP_ADD, 16'h0001, 16'h0001, 1'b1, mk_res(16'h0002, 0, 0, 0, 0)));
        vecs.push_back(mk_vec("sub_ovf",      OP_SUB, 16'h8000, 16'h0001, 1'b0, mk_res(16'h7FFF, 0, 0, 0, 1)));
        vecs.push_back(mk_vec("sub_borrow",   OP_SUB, 16'h7FFF, 16'hFFFF, 1'b0, mk_res(16'h8000, 0, 1, 1, 1)));
        vecs.push_back(mk_vec("sub_equal",    OP_SUB, 16'h1234, 16'h1234, 1'b0, mk_res(16'h0000, 1, 0, 0, 0)));
        vecs.push_back(mk_vec("dec_to_zero",  OP_DEC, 16'h0001, 16'hFFFF, 1'b0, mk_res(16'h0000, 1, 0, 0, 0)));
        vecs.push_back(mk_vec("dec_borrow",   OP_DEC, 16'h0000, 16'h0000, 1'b0, mk_res(16'hFFFF, 0, 1, 1, 0)));
        vecs.push_back(mk_vec("dec_ovf",      OP_DEC, 16'h8000, 16'h0000, 1'b0, mk_res(16'h7FFF, 0, 0, 0, 1)));
        vecs.push_back(mk_vec("inc_wrap",     OP_INC, 16'hFFFF, 16'h0000, 1'b0, mk_res(16'h0000, 1, 0, 1, 0)));
        vecs.push_back(mk_vec("inc_ovf",      OP_INC, 16'h7FFF, 16'h0000, 1'b0, mk_res(16'h8000, 0, 1, 0, 1)));
        vecs.push_back(mk_vec("shl",          OP_SHL, 16'h8001, 16'h0000, 1'b1, mk_res(16'h0002, 0, 0, 1, 1)));
        vecs.push_back(mk_vec("shr",          OP_SHR, 16'h8001, 16'h0000, 1'b1, mk_res(16'h4000, 0, 0, 1, 1)));
        vecs.push_back(mk_vec("asr",          OP_ASR, 16'h8001, 16'h0000, 1'b0, mk_res(16'hC000, 0, 1, 1, 0)));
        vecs.push_back(mk_vec("rrc",          OP_RRC, 16'h0001, 16'h0000, 1'b1, mk_res(16'h8000, 0, 1, 1, 1)));
        vecs.push_back(mk_vec("rlc",          OP_RLC, 16'h8001, 16'h0000, 1'b1, mk_res(16'h0003, 0, 0, 1, 1)));
        vecs.push_back(mk_vec("rlc_cin0",     OP_RLC, 16'h4000, 16'h0000, 1'b0, mk_res(16'h8000, 0, 1, 0, 1)));
        vecs.push_back(mk_vec("xor_zero",     OP_XOR, 16'hFFFF, 16'hFFFF, 1'b0, mk_res(16'h0000, 1, 0, 0, 0)));
        vecs.push_back(mk_vec("and",          OP_AND, 16'hF0F0, 16'h3C3C, 1'b0, mk_res(16'h3030, 0, 0, 0, 0)));
        vecs.push_back(mk_vec("or",           OP_OR,  16'hF0F0, 16'h0F0F, 1'b0, mk_res(16'hFFFF, 0, 1, 0, 0)));
        vecs.push_back(mk_vec("not",          OP_NOT, 16'h00FF, 16'h0000, 1'b0, mk_res(16'hFF00, 0, 1, 0, 0)));
        vecs.push_back(mk_vec("tsa",          OP_TSA, 16'h8000, 16'hFFFF, 1'b1, mk_res(16'h8000, 0, 1, 0, 0)));
        vecs.push_back(mk_vec("rsv",          OP_RSV, 16'h1234, 16'h5678, 1'b1, mk_res(16'h0000, 1, 0, 0, 0)));
`ifdef ALU16_BREV_EN
        vecs.push_back(mk_vec("brev",         OP_BREV, 16'h01FA, 16'h0000, 1'b0, mk_res(16'hFA01, 0, 1, 0, 0)));
`else
        vecs.push_back(mk_vec("brev_as_rsv",  OP_BREV, 16'h01FA, 16'h0000, 1'b0, mk_res(16'h0000, 1, 0, 0, 0)));
`endif

        foreach (vecs[i])
            apply(vecs[i].name, 1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp);

        // Random back-to-back vectors against the reference model
        for (int i = 0; i < 200; i++) begin
            op_e   op;
            word_t a, b;
            logic  cin;
            op  = op_e'($urandom_range(0, 15));
            a   = word_t'($urandom);
            b   = word_t'($urandom);
            cin = 1'($urandom_range(0, 1));
            apply("random", 1'b1, op, a, b, cin, model(op, a, b, cin));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu16.md
ALU16 -- requirements
Module: alu16

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 CLK  input  1  rising-edge clock; all outputs change only on this edge.
REQ-003 RESET_N  input  1  synchronous, active-low reset.
REQ-004 ABUS  input  16  operand A.
REQ-005 BBUS  input  16  operand B; used only by ADD, SUB, AND, OR, XOR.
REQ-006 FSEL  input  4  operation select.
REQ-007 CIN  input  1  carry-in; used only by RLC and RRC.
REQ-008 FOUT  output  16  registered result.
REQ-009 Z, S, C, V  output  1 each  registered zero, sign, carry/borrow and overflow flags.

Function
REQ-010 FOUT, Z, S, C and V SHALL be registered: the result for inputs sampled at a CLK edge is visible right after that edge, giving one-cycle latency.
REQ-011 The opcodes SHALL be: 0 TSA, 1 INC, 2 DEC, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 NOT, 9 SHL, A SHR, B ASR, C RLC, D RRC, E BREV, F RSV.
REQ-012 The results SHALL be:
- TSA: A.
- INC: A+1.
- DEC: A-1.
- ADD: A+B (CIN ignored).
- SUB: A-B.
- AND, OR, XOR: bitwise A with B.
- NOT: ~A.
- SHL: {A[14:0],0}.
- SHR: {0,A[15:1]}.
- ASR: {A[15],A[15:1]}.
- RLC: {A[14:0],CIN}.
- RRC: {CIN,A[15:1]}.
- BREV: {A[7:0],A[15:8]}.
- RSV: 16'h0000.
REQ-013 For every opcode, Z SHALL equal (FOUT==0) and S SHALL equal FOUT[15].
REQ-014 The C flag SHALL be:
- INC, ADD: the 17th-bit carry-out.
- DEC: the borrow (A==0).
- SUB: the borrow (A<B, unsigned).
- SHL, RLC: A[15].
- SHR, ASR, RRC: A[0].
- All other opcodes: 0.
REQ-015 The V flag SHALL be:
- INC, DEC, ADD, SUB: two's-complement signed overflow, with wrap-around modulo 2^16.
- SHL, SHR, RLC, RRC: A[15] XOR FOUT[15].
- ASR and all other opcodes: 0.

Reset
REQ-016 With RESET_N low at a CLK edge, FOUT SHALL become 0 and Z, S, C, V SHALL become 0.
REQ-017 Reset SHALL take priority over any operation in the same cycle.
REQ-018 The first edge after RESET_N returns high SHALL load a normal result.

Configuration
REQ-019 With macro ALU16_BREV_EN defined, opcode E SHALL perform BREV.
REQ-020 Without ALU16_BREV_EN, opcode E SHALL behave exactly as RSV: FOUT=0, Z=1, S=C=V=0.

Structure
REQ-021 The opcode constants and the 16-bit word width SHALL live in the shared package alu16_pkg.
REQ-022 ADD, SUB, INC and DEC SHALL share one sub-module, alu16_addsub, a 16-bit adder/subtractor with carry/borrow and overflow outputs.
REQ-023 All other logic SHALL be in alu16 as a combinational result mux feeding one output register.

Verification
REQ-024 A bench SHALL cover at least these scenarios:
- Reset: RESET_N=0 with ADD 1+1, one edge -> FOUT=0 and Z=S=C=V=0; release, next edge -> FOUT=2.
- ADD overflow: 8000+FFFF -> 7FFF, C=1, V=1; 7FFF+0001 -> 8000, S=1, C=0, V=1; FFFB+0006 -> 0001, C=1, V=0.
- SUB: 8000-0001 -> 7FFF, C=0, V=1; 7FFF-FFFF -> 8000, S=1, C=1, V=1; DEC 0001 -> 0000, Z=1, C=0.
- Shifts: SHL 8001 -> 0002, C=1, V=1; SHR 8001 -> 4000, C=1, V=1; ASR 8001 -> C000, S=1, C=1, V=0.
- Rotates: RRC 0001 with CIN=1 -> 8000, S=1, C=1, V=1; RLC 8001 with CIN=1 -> 0003, C=1, V=1.
- Logic and BREV: XOR FFFF^FFFF -> 0000, Z=1; BREV 01FA -> FA01, S=1 with the macro defined, and 0000, Z=1 without it.
